// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Optional per-requester grant counters on stat_grants when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [4*NUM_REQ-1:0]   req_op,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_result,
  output logic [3:0]             rsp_flags,
  output logic [3:0]             alu_op,
  output logic [31:0]            alu_operand1,
  output logic [31:0]            alu_operand2,
  input  logic [31:0]            alu_result,
  input  logic                   alu_zero,
  input  logic                   alu_negative,
  input  logic                   alu_overflow,
  input  logic                   alu_carry,
  output logic                   busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [32*NUM_REQ-1:0]  stat_grants
`endif
);

  // state | meaning
  // IDLE  | waiting for a request; grants one requester combinationally
  // EXEC  | ALU evaluates held operands for one cycle
  // RESP  | response held on rsp_* until rsp_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0] rr_last;
  logic [ID_W-1:0] winner;
  logic [ID_W:0]   cand;
  logic            found;
  logic            any_req;
  logic            accept;
  logic            capture;
  logic            release_rsp;
  logic [3:0]      sel_op;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;

  assign any_req = |req_valid;

  // Search from rr_last+1 upward with wrap; cand is one bit wider so the sum never overflows.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_last} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  // Constant-index mux so unknowns on losing slots cannot leak into the operand path.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_op = req_op[4*i +: 4];
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          release_rsp = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last      <= ID_W'(NUM_REQ - 1);
      alu_op       <= '0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      rsp_id       <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_flags    <= '0;
    end else begin
      if (accept) begin
        alu_op       <= sel_op;
        alu_operand1 <= sel_a;
        alu_operand2 <= sel_b;
        rsp_id       <= winner;
        rr_last      <= winner;
      end
      if (capture) begin
        rsp_result <= alu_result;
        rsp_flags  <= {alu_zero, alu_negative, alu_overflow, alu_carry};
        rsp_valid  <= 1'b1;
      end
      if (release_rsp) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [31:0] grant_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && (winner == ID_W'(i)) && (grant_cnt[i] != 32'hFFFF_FFFF)) begin
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_grants[32*i +: 32] = grant_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// against a round-robin reference model and a behavioural ALU.
module tb_alu_arbiter;

  localparam int N   = 2;
  localparam int IDW = $clog2(N);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [4*N-1:0]  req_op;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_result;
  logic [3:0]      rsp_flags;
  logic [3:0]      alu_op;
  logic [31:0]     alu_operand1;
  logic [31:0]     alu_operand2;
  logic [31:0]     alu_result;
  logic            alu_zero, alu_negative, alu_overflow, alu_carry;
  logic            busy;
`ifdef ALU_ARB_STATS_EN
  logic [32*N-1:0] stat_grants;
`endif

  logic [3:0]  r_op [N];
  logic [31:0] r_a  [N];
  logic [31:0] r_b  [N];

  int checks = 0;
  int errors = 0;
  int last;
  int grants [N];

  logic [31:0]    cap_result;
  logic [3:0]     cap_flags;
  logic [IDW-1:0] cap_id;
  int             cap_w;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .alu_op       (alu_op),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .alu_overflow (alu_overflow),
    .alu_carry    (alu_carry),
    .busy         (busy)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_grants  (stat_grants)
`endif
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_op[4*g +: 4]  = r_op[g];
    assign req_a[32*g +: 32] = r_a[g];
    assign req_b[32*g +: 32] = r_b[g];
  end

  // Behavioural ALU: {zero, negative, overflow, carry, result}
  function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        w = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = w[31:0]; c = w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = 32'($signed(a) >>> b[4:0]);
      OP_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: r = {31'd0, a < b};
      default: r = '0;
    endcase
    return {(r == 32'd0), r[31], v, c, r};
  endfunction

  always_comb begin
    {alu_zero, alu_negative, alu_overflow, alu_carry, alu_result} =
      alu_ref(alu_op, alu_operand1, alu_operand2);
  end

  function automatic int model_winner(input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE; hold = extra RESP cycles with rsp_ready low.
  task automatic txn(input logic [N-1:0] mask, input int hold);
    int          w;
    logic [35:0] exp;
    req_valid = mask;
    rsp_ready = (hold == 0);
    #1;
    w = model_winner(mask);
    chk("idle_req_ready", 64'(req_ready), 64'(1) << w);
    chk("idle_busy", 64'(busy), 64'd0);
    exp = alu_ref(r_op[w], r_a[w], r_b[w]);
    tick();
    last = w;
    grants[w]++;
    chk("exec_busy", 64'(busy), 64'd1);
    chk("exec_req_ready", 64'(req_ready), 64'd0);
    chk("exec_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("exec_alu_op", 64'(alu_op), 64'(r_op[w]));
    chk("exec_operand1", 64'(alu_operand1), 64'(r_a[w]));
    chk("exec_operand2", 64'(alu_operand2), 64'(r_b[w]));
    tick();
    cap_result = rsp_result;
    cap_flags  = rsp_flags;
    cap_id     = rsp_id;
    cap_w      = w;
    chk("resp_valid", 64'(rsp_valid), 64'd1);
    chk("resp_id", 64'(rsp_id), 64'(w));
    chk("resp_result", 64'(rsp_result), 64'(exp[31:0]));
    chk("resp_flags", 64'(rsp_flags), 64'(exp[35:32]));
    chk("resp_req_ready", 64'(req_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_id", 64'(rsp_id), 64'(w));
      chk("hold_result", 64'(rsp_result), 64'(exp[31:0]));
      chk("hold_flags", 64'(rsp_flags), 64'(exp[35:32]));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
    end
    rsp_ready = 1'b1;
    tick();
    chk("done_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("done_busy", 64'(busy), 64'd0);
    req_valid = '0;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    last      = N - 1;
    for (int i = 0; i < N; i++) grants[i] = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic chk_stats();
    for (int i = 0; i < N; i++) begin
      chk("stat_grants", 64'(stat_grants[32*i +: 32]), 64'(grants[i]));
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) begin
      r_op[i] = OP_ADD; r_a[i] = '0; r_b[i] = '0;
    end
    do_reset();

    // Reset values
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_operand1", 64'(alu_operand1), 64'd0);
    chk("rst_operand2", 64'(alu_operand2), 64'd0);

    // Round-robin: both requesters hold valid with 5-5
    for (int i = 0; i < N; i++) begin
      r_op[i] = OP_SUB; r_a[i] = 32'd5; r_b[i] = 32'd5;
    end
    for (int t = 0; t < 4; t++) begin
      txn(2'b11, 0);
      chk("rr_order", 64'(cap_id), 64'(t % 2));
      chk("rr_result", 64'(cap_result), 64'd0);
      chk("rr_flags", 64'(cap_flags), 64'b1001);
    end

    // Single add with unknowns on the idle requester's slots
    r_op[0] = OP_ADD; r_a[0] = 32'h7FFF_FFFF; r_b[0] = 32'd1;
    r_op[1] = 'x;     r_a[1] = 'x;            r_b[1] = 'x;
    txn(2'b01, 0);
    chk("add_result", 64'(cap_result), 64'h8000_0000);
    chk("add_flags", 64'(cap_flags), 64'b0110);
    chk("add_id", 64'(cap_id), 64'd0);

    // Backpressure: five cycles of rsp_ready low, other requester waiting
    r_op[1] = OP_XOR; r_a[1] = 32'hDEAD_BEEF; r_b[1] = 32'h1234_5678;
    r_op[0] = OP_AND; r_a[0] = 32'hFFFF_0000; r_b[0] = 32'h0F0F_0F0F;
    txn(2'b11, 5);
    chk("bp_id", 64'(cap_id), 64'd1);
    chk("bp_result", 64'(cap_result), 64'hCC99_E897);

    // Shift and compare
    r_op[0] = OP_SRA; r_a[0] = 32'h8000_0000; r_b[0] = 32'h0000_0024;
    txn(2'b01, 0);
    chk("sra_result", 64'(cap_result), 64'hF800_0000);
    r_op[1] = OP_SLT; r_a[1] = 32'hFFFF_FFFF; r_b[1] = 32'd0;
    txn(2'b10, 1);
    chk("slt_result", 64'(cap_result), 64'd1);

    // Randomized traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] mask;
      for (int i = 0; i < N; i++) begin
        r_op[i] = 4'($urandom_range(0, 9));
        r_a[i]  = $urandom;
        r_b[i]  = ($urandom_range(0, 3) == 0) ? r_a[i] : $urandom;
      end
      mask = N'($urandom_range(1, (1 << N) - 1));
      txn(mask, $urandom_range(0, 2));
    end
`ifdef ALU_ARB_STATS_EN
    chk_stats();
`endif

    // Reset mid-operation: requester 1 granted, reset during EXEC
    r_op[1] = OP_OR; r_a[1] = 32'h0000_00F0; r_b[1] = 32'h0000_000F;
    req_valid = 2'b10;
    rsp_ready = 1'b1;
    #1;
    chk("pre_rst_ready", 64'(req_ready), 64'b10);
    tick();
    chk("pre_rst_exec", 64'(busy), 64'd1);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_alu_op", 64'(alu_op), 64'd0);
    chk("midrst_operand1", 64'(alu_operand1), 64'd0);
    chk("midrst_rsp_id", 64'(rsp_id), 64'd0);
    last = N - 1;
    for (int i = 0; i < N; i++) grants[i] = 0;
    tick();
    chk("midrst_hold_valid", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    r_op[0] = OP_ADD; r_a[0] = 32'd3; r_b[0] = 32'd4;
    txn(2'b11, 0);
    chk("post_rst_first", 64'(cap_id), 64'd0);
    chk("post_rst_result", 64'(cap_result), 64'd7);

`ifdef ALU_ARB_STATS_EN
    do_reset();
    for (int t = 0; t < 3; t++) txn(2'b10, 0);
    chk("stats_req1", 64'(stat_grants[63:32]), 64'd3);
    chk("stats_req0", 64'(stat_grants[31:0]), 64'd0);
    chk_stats();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational ALU instance between NUM_REQ requesters, such as the integer issue port, the address-generation sequencer and the debug unit. It performs round-robin arbitration over valid/ready request channels and registers the winning request into the ALU operand path. It then captures the ALU result and flags into a response register and holds them on a valid/ready response channel that is tagged with the requester ID. The block sits between the issue logic and the ALU; the ALU itself is unchanged.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..8.
ID_W, $clog2(NUM_REQ), width of the response ID (derived; do not override).

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NUM_REQ  per-requester request valid.
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
req_op  input  4*NUM_REQ  ALU op for requester i in slice [4i+3:4i]; sigma_pkg encodings.
req_a  input  32*NUM_REQ  operand1 for requester i in slice [32i+31:32i].
req_b  input  32*NUM_REQ  operand2 for requester i in slice [32i+31:32i].
rsp_valid  output  1  response valid.
rsp_ready  input  1  response accept.
rsp_id  output  ID_W  index of the requester that owns the response.
rsp_result  output  32  captured ALU result.
rsp_flags  output  4  captured flags as {zero, negative, overflow, carry}.
alu_op  output  4  drives the ALU op input.
alu_operand1  output  32  drives ALU operand1.
alu_operand2  output  32  drives ALU operand2.
alu_result  input  32  ALU result.
alu_zero, alu_negative, alu_overflow, alu_carry  input  1 each  ALU flags.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: FSM=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_result=0; rsp_flags=0; alu_op/alu_operand1/alu_operand2 registers=0; rr_last=NUM_REQ-1, so requester 0 has priority first; busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE, acceptance: if any req_valid is high, select the winner w as the first set bit searching from rr_last+1 upward, wrapping modulo NUM_REQ. req_ready[w]=1 combinationally in that same cycle.
- IDLE, on the clock edge after acceptance: latch req_op[w], req_a[w], req_b[w] into the ALU drive registers; latch w into the ID register; set rr_last=w; go to EXEC.
- IDLE, no request: if no req_valid is high, stay in IDLE and leave rr_last unchanged.
- req_ready is asserted only in IDLE and never to more than one requester.
- EXEC: the ALU evaluates the held operands. At the clock edge, capture alu_result and the four flags into rsp_result/rsp_flags, set rsp_valid=1, and go to RESP. EXEC lasts exactly 1 cycle.
- RESP: hold rsp_valid, rsp_id, rsp_result and rsp_flags stable until rsp_ready=1. On the clock edge with rsp_valid&&rsp_ready, clear rsp_valid and go to IDLE.
- RESP does not accept a new request in the same cycle; a new request cannot be accepted before the following cycle.
- Latency: accepted at cycle N, rsp_valid first high at N+2.
- Throughput: at most 1 operation per 3 cycles with rsp_ready tied high.
- Hold rule: while in EXEC and RESP, the ALU drive registers hold their values and are not updated from the request inputs.
- Request-side changes: a requester that drops req_valid while not granted is simply not selected. Request inputs are ignored outside IDLE.
- Fairness: a requester that keeps req_valid high is granted within NUM_REQ grants.
- Unused requester slots: X on req_op, req_a or req_b of a non-winning requester must not propagate to any output.
- Reset mid-operation: the response is discarded, rsp_valid drops to 0 immediately (asynchronously), and the FSM returns to IDLE.
- rsp_id: carries the winner index, zero-extended to ID_W.

Optional Feature:
ALU_ARB_STATS_EN:
- When defined, add output stat_grants (32*NUM_REQ): per-requester grant counters.
- Each counter increments on every acceptance for that requester and saturates at 32'hFFFF_FFFF.
- Counters reset to 0.
- When not defined, the port and the counters are absent, and all other behaviour is identical.

Test Plan:
- Single add: requester 0 sends ALU_ADD, a=32'h7FFF_FFFF, b=1, with rsp_ready=1. Required response: rsp_valid at cycle N+2, rsp_result=32'h8000_0000, flags={0,1,1,0}, rsp_id=0.
- Round-robin: both requesters hold req_valid with ALU_SUB 5-5, responses always accepted. Grant order must be 0,1,0,1. Every response has rsp_result=0 and flags={1,0,0,1}.
- Backpressure: hold rsp_ready=0 for 5 cycles during RESP. rsp_valid, rsp_id and rsp_result stay stable, and req_ready stays 0 throughout. The first rsp_ready=1 completes the transaction and the FSM returns to IDLE the next cycle.
- Shift and compare: ALU_SRA with a=32'h8000_0000, b=32'h0000_0024 must give rsp_result=32'hF800_0000, since only the low 5 bits of b (shift 4) are used. ALU_SLT with a=32'hFFFF_FFFF, b=0 must give rsp_result=1.
- Reset mid-op: assert rst_n=0 during EXEC. rsp_valid=0, busy=0, outputs return to reset values. After release, requester 0 wins first even if requester 1 was granted last.
- With ALU_ARB_STATS_EN defined: perform 3 grants to requester 1. Required: stat_grants[63:32]=3 and stat_grants[31:0]=0.
